uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries; power of two, 2..256.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, meaning width of the runtime baud divisor.
REQ-004 SHALL have port clk  input  1  meaning the single clock for all logic.
REQ-005 SHALL have port rstn  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port s_valid  input  1  meaning the upstream word is valid.
REQ-007 SHALL have port s_data  input  DATA_BITS  meaning the upstream data word, sent LSB first.
REQ-008 SHALL have port s_ready  output  1  meaning the FIFO can accept a word.
REQ-009 SHALL have port cfg_div  input  DIV_WIDTH  meaning clocks per bit; a value of 0 is treated as 1.
REQ-010 SHALL have port cfg_parity  input  2  meaning parity mode: 00 none, 01 odd, 10 even, 11 none.
REQ-011 SHALL have port cfg_stop2  input  1  meaning 1 selects two stop bits, 0 selects one.
REQ-012 SHALL have port tx  output  1  meaning the serial line, idle high.
REQ-013 SHALL have port busy  output  1  meaning the FSM is not in IDLE.
REQ-014 SHALL have port tx_done  output  1  meaning a one-cycle pulse after the last stop bit completes.
REQ-015 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  meaning the number of words held in the FIFO.

Function
REQ-016 SHALL accept a word on every rising clk edge where s_valid && s_ready, writing it into the FIFO.
REQ-017 SHALL drive s_ready = (fifo_count != FIFO_DEPTH), combinationally from registered count; a push at full is blocked even when a pop occurs in the same cycle.
REQ-018 SHALL on a simultaneous push and pop leave fifo_count unchanged and preserve FIFO order; pointers wrap modulo FIFO_DEPTH.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 SHALL in IDLE, when fifo_count != 0, pop the head word and latch it together with cfg_div, cfg_parity and cfg_stop2, then enter START; cfg changes mid-frame have no effect on the current frame.
REQ-021 SHALL hold each bit for exactly max(cfg_div,1) clocks, using a bit-clock counter that resets at every bit boundary.
REQ-022 SHALL drive tx=0 in START for 1 bit, then enter DATA.
REQ-023 SHALL in DATA send DATA_BITS bits LSB first, then enter PARITY if parity mode is 01/10, else STOP.
REQ-024 SHALL in PARITY send the XOR of the data bits for even mode and its inverse for odd mode, then enter STOP.
REQ-025 SHALL in STOP drive tx=1 for 1 or 2 bits per the latched cfg_stop2.
REQ-026 SHALL at the final clock of STOP pulse tx_done for one cycle; if the FIFO is non-empty, pop in that same cycle and enter START with no idle gap, otherwise enter IDLE.
REQ-027 SHALL drive tx high in IDLE, and drive tx from a register (glitch-free).
REQ-028 SHALL have latency such that a push at edge k into an empty FIFO with the FSM in IDLE causes the pop at edge k+1, with tx low after edge k+1.
REQ-029 SHALL have a frame length of 1+DATA_BITS+P+S bits, where P∈{0,1} and S∈{1,2}.

Reset
REQ-030 SHALL on rstn low immediately set: state IDLE, tx=1, busy=0, tx_done=0, fifo_count=0, s_ready=1, and all counters and pointers 0.
REQ-031 SHALL abort a frame in progress on reset mid-frame, with tx returning high asynchronously and FIFO contents discarded.
REQ-032 SHALL accept no push while rstn is low.

Verification
REQ-033 SHALL be verified with: DATA_BITS=8, cfg_div=4, parity none, 1 stop, push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; tx_done after 40 clocks; busy low after.
REQ-034 SHALL be verified with: cfg_parity=10 then 01, push 0x07 -> parity bit 1 (even) and 0 (odd); with cfg_stop2=1 the frame is 12 bits long.
REQ-035 SHALL be verified with: cfg_div=1, s_valid held high with 20 words at FIFO_DEPTH=16 -> s_ready drops at count 16, all 20 words are sent in order back-to-back with no idle cycle between frames.
REQ-036 SHALL be verified with: cfg_div changed from 4 to 8 mid-frame -> the current frame stays at 4 clocks per bit and the next frame uses 8.
REQ-037 SHALL be verified with: rstn asserted during DATA with 3 words queued -> tx=1 and fifo_count=0 immediately; after release, nothing is transmitted.
REQ-038 SHALL be verified with: cfg_div=0 -> identical behaviour to cfg_div=1; DATA_BITS=5 build, push 0x1F -> 7-bit frame (1 start, 5 data, 1 stop).

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// This block is a UART transmitter with a transmit FIFO in front of it.
// Upstream words enter through a valid/ready handshake and are queued in the
// FIFO. The framing FSM takes words from the FIFO and serialises each one as:
//   start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//   then one or two stop bits (1).
// The baud divisor, parity mode and stop-bit count are latched once at the
// start of each frame, so changing them mid-frame only affects later frames.
//
// Parameters
//   DATA_BITS  : data bits per frame (5..9)
//   FIFO_DEPTH : transmit FIFO entries (power of two, 2..256)
//   DIV_WIDTH  : width of the runtime baud divisor
//
// Ports
//   clk        : single clock for all logic
//   rstn       : asynchronous active-low reset
//   s_valid    : upstream word valid
//   s_data     : upstream data word (sent LSB first)
//   s_ready    : FIFO can accept a word
//   cfg_div    : clocks per bit (0 is treated as 1)
//   cfg_parity : 00 none, 01 odd, 10 even, 11 none
//   cfg_stop2  : 1 = two stop bits, 0 = one stop bit
//   tx         : serial line, idle high, driven from a register
//   busy       : FSM is not in IDLE
//   tx_done    : one-cycle pulse after the last stop bit of a frame
//   fifo_count : number of words held in the FIFO
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_valid,
    input  logic [DATA_BITS-1:0]          s_data,
    output logic                          s_ready,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // -----------------------------------------------------------------------
    // Transmit FIFO
    // -----------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 push_w;
    logic                 pop_w;
    logic [DATA_BITS-1:0] head_w;

    // Ready depends only on the registered count, so a push at full is
    // refused even if the FSM pops in the same cycle.
    assign s_ready    = (count_q != CW'(FIFO_DEPTH));
    assign push_w     = s_valid && s_ready;
    assign head_w     = mem_q[rd_ptr_q];
    assign fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage is not reset; only pointers and count define valid contents.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // -----------------------------------------------------------------------
    // Framing FSM
    // -----------------------------------------------------------------------
    state_e               state_q;
    logic [DIV_WIDTH-1:0] clk_cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [3:0]           bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 stop2_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic [DIV_WIDTH-1:0] div_eff_w;
    logic                 bit_end_w;
    logic                 last_data_w;
    logic                 frame_end_w;
    logic                 par_en_w;
    logic                 par_bit_w;

    assign div_eff_w   = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
    // Bit-clock counter runs 0 .. div-1 and restarts at every bit boundary.
    assign bit_end_w   = (clk_cnt_q == (div_q - DIV_WIDTH'(1)));
    assign last_data_w = (bit_idx_q == 4'(DATA_BITS - 1));
    assign frame_end_w = (state_q == S_STOP) && bit_end_w &&
                         (!stop2_q || stop_idx_q);

    // Parity enabled for modes 01 and 10 only; odd mode inverts the XOR.
    assign par_en_w    = ^cfg_parity;
    assign par_bit_w   = (^head_w) ^ (cfg_parity == 2'b01);

    // A pop happens either from IDLE or on the final clock of a frame, which
    // lets the next frame start with no idle gap.
    assign pop_w = (count_q != '0) && ((state_q == S_IDLE) || frame_end_w);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end

                S_START: begin
                    if (bit_end_w) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        state_q   <= S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + DIV_WIDTH'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end_w) begin
                        clk_cnt_q <= '0;
                        if (last_data_w) begin
                            if (par_en_q) begin
                                tx_q    <= par_bit_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                stop_idx_q <= 1'b0;
                                state_q    <= S_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + DIV_WIDTH'(1);
                    end
                end

                S_PARITY: begin
                    if (bit_end_w) begin
                        clk_cnt_q  <= '0;
                        tx_q       <= 1'b1;
                        stop_idx_q <= 1'b0;
                        state_q    <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + DIV_WIDTH'(1);
                    end
                end

                S_STOP: begin
                    if (bit_end_w) begin
                        clk_cnt_q <= '0;
                        if (frame_end_w) begin
                            done_q  <= 1'b1;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + DIV_WIDTH'(1);
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase

            // Loading a new frame overrides the IDLE/STOP transitions above
            // and snapshots the configuration for the whole frame.
            if (pop_w) begin
                state_q    <= S_START;
                tx_q       <= 1'b0;
                busy_q     <= 1'b1;
                clk_cnt_q  <= '0;
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
                shift_q    <= head_w;
                div_q      <= div_eff_w;
                par_en_q   <= par_en_w;
                par_bit_q  <= par_bit_w;
                stop2_q    <= cfg_stop2;
            end
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;

    // Default build: DATA_BITS=8, FIFO_DEPTH=16
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic [15:0] cfg_div = 16'd4;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        tx;
    logic        busy;
    logic        tx_done;
    logic [4:0]  fifo_count;

    // DATA_BITS=5 build
    logic        s_valid5 = 1'b0;
    logic [4:0]  s_data5 = 5'h00;
    logic        s_ready5;
    logic [15:0] cfg5_div = 16'd2;
    logic [1:0]  cfg5_parity = 2'b00;
    logic        cfg5_stop2 = 1'b0;
    logic        tx5;
    logic        busy5;
    logic        tx_done5;
    logic [4:0]  fifo_count5;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count)
    );

    uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut5 (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid5), .s_data(s_data5), .s_ready(s_ready5),
        .cfg_div(cfg5_div), .cfg_parity(cfg5_parity), .cfg_stop2(cfg5_stop2),
        .tx(tx5), .busy(busy5), .tx_done(tx_done5), .fifo_count(fifo_count5)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] wgen(input int i);
        return 8'(i * 37 + 5);
    endfunction

    // Push one word into the 8-bit DUT; returns at the negedge just before
    // the pop edge, where the line must still be idle.
    task automatic push1(input string tag, input logic [7:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
        check({tag, " count after push"}, 32'(fifo_count), 32'd1);
        check({tag, " tx idle before pop"}, 32'(tx), 32'd1);
    endtask

    // Called at the last-stop-clock negedge of the frame: expect the
    // tx_done pulse, then a return to idle.
    task automatic end_idle(input string tag);
        @(negedge clk);
        check({tag, " tx_done pulse"}, 32'(tx_done), 32'd1);
        check({tag, " busy low"}, 32'(busy), 32'd0);
        check({tag, " tx idle"}, 32'(tx), 32'd1);
        @(negedge clk);
        check({tag, " tx_done single"}, 32'(tx_done), 32'd0);
    endtask

    // Check every clock of one frame. Starts at the negedge before the pop
    // edge and returns at the negedge of the final stop clock.
    task automatic expect_frame(input int sel, input string tag, input logic [8:0] data,
                                input int nd, input int pen, input logic pval,
                                input int nstop, input int div,
                                input int new_div, input int nxt);
        logic [12:0] exp_v;
        int nb;
        exp_v = '0;
        nb = 1 + nd + pen + nstop;
        exp_v[0] = 1'b0;
        for (int i = 0; i < nd; i++) exp_v[1 + i] = data[i];
        if (pen != 0) exp_v[1 + nd] = pval;
        for (int s = 0; s < nstop; s++) exp_v[1 + nd + pen + s] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                if (sel == 0 && b == 2 && c == 0) begin
                    if (new_div >= 0) cfg_div = 16'(new_div);
                    if (nxt >= 0) begin
                        s_valid = 1'b1;
                        s_data  = 8'(nxt);
                    end
                end
                if (sel == 0 && b == 2 && c == 1 && nxt >= 0) s_valid = 1'b0;
                check($sformatf("%s bit%0d clk%0d tx", tag, b, c),
                      32'(sel != 0 ? tx5 : tx), 32'(exp_v[b]));
                if (c == 0 && b > 0)
                    check($sformatf("%s bit%0d busy", tag, b),
                          32'(sel != 0 ? busy5 : busy), 32'd1);
                if (b == nb - 1 && c == div - 1)
                    check($sformatf("%s no early done", tag),
                          32'(sel != 0 ? tx_done5 : tx_done), 32'd0);
            end
        end
    endtask

    initial begin
        int idx;
        int maxc;
        bit saw_full;
        bit rdy_prev;
        bit went_low;
        int t;
        logic [7:0] w;
        logic expb;

        // ---------------- reset state ----------------
        #1 rstn = 1'b0;
        #1;
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset tx_done", 32'(tx_done), 32'd0);
        check("reset fifo_count", 32'(fifo_count), 32'd0);
        check("reset s_ready", 32'(s_ready), 32'd1);
        check("reset5 s_ready", 32'(s_ready5), 32'd1);
        check("reset5 tx", 32'(tx5), 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // ---------------- 0xA5, div 4, no parity, 1 stop ----------------
        cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        push1("a5", 8'hA5);
        expect_frame(0, "a5", 9'h0A5, 8, 0, 1'b0, 1, 4, -1, -1);
        end_idle("a5");

        // ---------------- parity even / odd on 0x07 ----------------
        cfg_parity = 2'b10;
        push1("even", 8'h07);
        expect_frame(0, "even", 9'h007, 8, 1, 1'b1, 1, 4, -1, -1);
        end_idle("even");

        cfg_parity = 2'b01;
        push1("odd", 8'h07);
        expect_frame(0, "odd", 9'h007, 8, 1, 1'b0, 1, 4, -1, -1);
        end_idle("odd");

        // even parity + two stop bits: 12-bit frame
        cfg_parity = 2'b10; cfg_stop2 = 1'b1;
        push1("stop2", 8'h07);
        expect_frame(0, "stop2", 9'h007, 8, 1, 1'b1, 2, 4, -1, -1);
        end_idle("stop2");

        // parity mode 11 behaves as none
        cfg_parity = 2'b11; cfg_stop2 = 1'b0;
        push1("par11", 8'h81);
        expect_frame(0, "par11", 9'h081, 8, 0, 1'b0, 1, 4, -1, -1);
        end_idle("par11");

        // ---------------- streaming 20 words at div 1 ----------------
        cfg_div = 16'd1; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        idx = 0; maxc = 0; saw_full = 1'b0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data = wgen(0);
        rdy_prev = s_ready;
        for (int cyc = 1; cyc <= 205; cyc++) begin
            @(negedge clk);
            if (s_valid && rdy_prev) idx++;
            if (cyc == 1) check("stream tx idle before pop", 32'(tx), 32'd1);
            if (cyc >= 2 && cyc < 202) begin
                t = cyc - 2;
                w = wgen(t / 10);
                if (t % 10 == 0) expb = 1'b0;
                else if (t % 10 == 9) expb = 1'b1;
                else expb = w[(t % 10) - 1];
                check($sformatf("stream word%0d bit%0d tx", t / 10, t % 10), 32'(tx), 32'(expb));
            end
            if (cyc == 202) begin
                check("stream final tx_done", 32'(tx_done), 32'd1);
                check("stream final tx", 32'(tx), 32'd1);
            end
            if (!s_ready) begin
                saw_full = 1'b1;
                check($sformatf("stream count when not ready cyc%0d", cyc), 32'(fifo_count), 32'd16);
            end
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            s_valid = (idx < 20);
            s_data = wgen(idx);
            rdy_prev = s_ready;
        end
        s_valid = 1'b0;
        check("stream words accepted", 32'(idx), 32'd20);
        check("stream saw full", 32'(saw_full), 32'd1);
        check("stream max count", 32'(maxc), 32'd16);
        check("stream busy after", 32'(busy), 32'd0);
        check("stream count after", 32'(fifo_count), 32'd0);

        // ---------------- cfg_div change mid-frame ----------------
        cfg_div = 16'd4;
        push1("div4", 8'h3C);
        expect_frame(0, "div4", 9'h03C, 8, 0, 1'b0, 1, 4, 8, 'hC3);
        expect_frame(0, "div8", 9'h0C3, 8, 0, 1'b0, 1, 8, -1, -1);
        end_idle("div8");

        // ---------------- reset during DATA with 3 queued ----------------
        cfg_div = 16'd4;
        @(negedge clk);
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = wgen(40 + i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset count", 32'(fifo_count), 32'd3);
        check("pre-reset busy", 32'(busy), 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("async reset tx", 32'(tx), 32'd1);
        check("async reset count", 32'(fifo_count), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data = 8'hFF;
        repeat (3) @(negedge clk);
        check("no push in reset", 32'(fifo_count), 32'd0);
        s_valid = 1'b0;
        rstn = 1'b1;
        went_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) went_low = 1'b1;
        end
        check("nothing sent after reset", 32'(went_low), 32'd0);
        check("count after reset", 32'(fifo_count), 32'd0);

        // ---------------- cfg_div = 0 acts as 1 ----------------
        cfg_div = 16'd0;
        push1("div0", 8'h5A);
        expect_frame(0, "div0", 9'h05A, 8, 0, 1'b0, 1, 1, -1, -1);
        end_idle("div0");

        // ---------------- DATA_BITS=5 build, 0x1F ----------------
        @(negedge clk);
        s_valid5 = 1'b1;
        s_data5 = 5'h1F;
        @(negedge clk);
        s_valid5 = 1'b0;
        check("db5 count after push", 32'(fifo_count5), 32'd1);
        check("db5 tx idle before pop", 32'(tx5), 32'd1);
        expect_frame(1, "db5", 9'h01F, 5, 0, 1'b0, 1, 2, -1, -1);
        @(negedge clk);
        check("db5 tx_done pulse", 32'(tx_done5), 32'd1);
        check("db5 busy low", 32'(busy5), 32'd0);
        check("db5 tx idle", 32'(tx5), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
